fp_add_arbiter: RTL and testbench

- Shares one combinational fp_adder datapath between two requesters. Format: 13-bit packed word {sign[12], exp[11:8], frac[7:0]}.
- Arbitrates requests round-robin and registers the operands onto the adder inputs.
- Waits a programmable settle time, captures the adder result, and returns it with the requester ID over a valid/ready response channel.
- Sits between requesting engines and a single fp_adder instance; the adder is instantiated outside this block.

---
 rtl/fp_add_arbiter.sv | 140 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin front end that time-shares one external combinational fp_adder
// between two requesters and returns each result with its requester id.
module fp_add_arbiter #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [12:0]      req0_a,
   input  logic [12:0]      req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [12:0]      req1_a,
   input  logic [12:0]      req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [12:0]      rsp_result,
   output logic             add_sign1,
   output logic             add_sign2,
   output logic [3:0]       add_exp1,
   output logic [3:0]       add_exp2,
   output logic [7:0]       add_frac1,
   output logic [7:0]       add_frac2,
   input  logic             add_sign_out,
   input  logic [3:0]       add_exp_out,
   input  logic [7:0]       add_frac_out,
   output logic             busy,
   output logic [CNT_W-1:0] done_count,
   output logic [1:0]       dbg_state
);

   // Valid/ready: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready and holds its payload until taken.
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t           r_state, w_next;
   logic             r_last_grant, r_id, r_rsp_valid, r_rsp_id;
   logic [12:0]      r_rsp_result;
   logic [3:0]       r_cnt;
   logic             r_sign1, r_sign2;
   logic [3:0]       r_exp1, r_exp2;
   logic [7:0]       r_frac1, r_frac2;
   logic [CNT_W-1:0] r_done;
   logic             w_grant, w_accept, w_settle_done;
   logic [12:0]      w_a, w_b;
   logic             w_sub;

   assign w_settle_done = (r_cnt == SETTLE_LAST);
   assign w_a   = w_grant ? req1_a   : req0_a;
   assign w_b   = w_grant ? req1_b   : req0_b;
   assign w_sub = w_grant ? req1_sub : req0_sub;

   always_comb begin
      w_next     = r_state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      w_accept   = 1'b0;
      // On a tie the requester that did not win last time goes first.
      w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
      case (r_state)
         IDLE: begin
            req0_ready = req0_valid && !w_grant;
            req1_ready = req1_valid && w_grant;
            w_accept   = req0_valid || req1_valid;
            if (w_accept) w_next = SETTLE;
         end
         SETTLE: if (w_settle_done) w_next = RESP;
         RESP:   if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_cnt        <= 4'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= 13'd0;
         r_sign1      <= 1'b0;
         r_sign2      <= 1'b0;
         r_exp1       <= 4'd0;
         r_exp2       <= 4'd0;
         r_frac1      <= 8'd0;
         r_frac2      <= 8'd0;
         r_done       <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (w_accept) begin
               r_sign1      <= w_a[12];
               r_exp1       <= w_a[11:8];
               r_frac1      <= w_a[7:0];
               r_sign2      <= w_b[12] ^ w_sub;
               r_exp2       <= w_b[11:8];
               r_frac2      <= w_b[7:0];
               r_id         <= w_grant;
               r_last_grant <= w_grant;
               r_cnt        <= 4'd0;
            end
            SETTLE: begin
               r_cnt <= r_cnt + 4'd1;
               if (w_settle_done) begin
                  r_rsp_result <= {add_sign_out, add_exp_out, add_frac_out};
                  r_rsp_id     <= r_id;
                  r_rsp_valid  <= 1'b1;
               end
            end
            RESP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_done      <= r_done + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign add_sign1  = r_sign1;
   assign add_sign2  = r_sign2;
   assign add_exp1   = r_exp1;
   assign add_exp2   = r_exp2;
   assign add_frac1  = r_frac1;
   assign add_frac2  = r_frac2;
   assign busy       = (r_state != IDLE);
   assign done_count = r_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench: two arbiter instances (settle 1 and 3) share stimulus; a
// behavioural adder with a settle window feeds each, and one monitor checks.
module tb_fp_add_arbiter;

   localparam int S0 = 1;
   localparam int S1 = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;
   logic rr = 1'b1;
   logic [1:0] v = 2'b00;
   logic [1:0][12:0] op_a, op_b;
   logic [1:0] op_s;

   logic [1:0] r0rdy, r1rdy, rspv, rspid, bsy, as1, as2;
   logic [1:0][3:0] ae1, ae2;
   logic [1:0][7:0] af1, af2;
   logic [1:0][12:0] rres, sum_o;
   logic [1:0][1:0] dbg;
   logic [7:0] dc0;
   logic [3:0] dc1;

   int n_tests = 0;
   int n_fail = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural adder ----------------
   function automatic logic [12:0] fp_add(input logic [12:0] x, input logic [12:0] y);
      longint mx, my, s;
      logic [39:0] mag, sh;
      int p, e;
      mx = longint'(x[7:0]);
      if (x[11:8] != 4'd0) mx = mx + 256;
      mx = mx << x[11:8];
      if (x[12]) mx = -mx;
      my = longint'(y[7:0]);
      if (y[11:8] != 4'd0) my = my + 256;
      my = my << y[11:8];
      if (y[12]) my = -my;
      s = mx + my;
      if (s == 0) return 13'd0;
      mag = (s < 0) ? 40'(-s) : 40'(s);
      p = 0;
      for (int i = 0; i < 40; i++) if (mag[i]) p = i;
      if (p <= 8) return {s < 0, 4'd0, mag[7:0]};
      e = p - 8;
      if (e > 15) return {s < 0, 4'hf, 8'hff};
      sh = mag >> e;
      return {s < 0, 4'(e), sh[7:0]};
   endfunction

   // Adder output is only trustworthy once its inputs have been stable long
   // enough; before that it shows a junk pattern.
   logic [25:0] prev0 = '0, prev1 = '0;
   int stab0 = 0, stab1 = 0;
   always @(negedge clk) begin
      if ({as1[0], ae1[0], af1[0], as2[0], ae2[0], af2[0]} == prev0) begin
         if (stab0 < 100) stab0 <= stab0 + 1;
      end else stab0 <= 0;
      prev0 <= {as1[0], ae1[0], af1[0], as2[0], ae2[0], af2[0]};
      if ({as1[1], ae1[1], af1[1], as2[1], ae2[1], af2[1]} == prev1) begin
         if (stab1 < 100) stab1 <= stab1 + 1;
      end else stab1 <= 0;
      prev1 <= {as1[1], ae1[1], af1[1], as2[1], ae2[1], af2[1]};
   end
   assign sum_o[0] = (stab0 >= S0 - 1) ? fp_add({as1[0], ae1[0], af1[0]}, {as2[0], ae2[0], af2[0]}) : 13'h1555;
   assign sum_o[1] = (stab1 >= S1 - 1) ? fp_add({as1[1], ae1[1], af1[1]}, {as2[1], ae2[1], af2[1]}) : 13'h1555;

   // ---------------- DUTs ----------------
   fp_add_arbiter #(.SETTLE_CYCLES(S0), .CNT_W(8)) u_dut0 (
      .clk(clk), .reset(reset),
      .req0_valid(v[0] && !sel), .req0_ready(r0rdy[0]), .req0_a(op_a[0]), .req0_b(op_b[0]), .req0_sub(op_s[0]),
      .req1_valid(v[1] && !sel), .req1_ready(r1rdy[0]), .req1_a(op_a[1]), .req1_b(op_b[1]), .req1_sub(op_s[1]),
      .rsp_valid(rspv[0]), .rsp_ready(rr && !sel), .rsp_id(rspid[0]), .rsp_result(rres[0]),
      .add_sign1(as1[0]), .add_sign2(as2[0]), .add_exp1(ae1[0]), .add_exp2(ae2[0]),
      .add_frac1(af1[0]), .add_frac2(af2[0]),
      .add_sign_out(sum_o[0][12]), .add_exp_out(sum_o[0][11:8]), .add_frac_out(sum_o[0][7:0]),
      .busy(bsy[0]), .done_count(dc0), .dbg_state(dbg[0]));

   fp_add_arbiter #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(v[0] && sel), .req0_ready(r0rdy[1]), .req0_a(op_a[0]), .req0_b(op_b[0]), .req0_sub(op_s[0]),
      .req1_valid(v[1] && sel), .req1_ready(r1rdy[1]), .req1_a(op_a[1]), .req1_b(op_b[1]), .req1_sub(op_s[1]),
      .rsp_valid(rspv[1]), .rsp_ready(rr && sel), .rsp_id(rspid[1]), .rsp_result(rres[1]),
      .add_sign1(as1[1]), .add_sign2(as2[1]), .add_exp1(ae1[1]), .add_exp2(ae2[1]),
      .add_frac1(af1[1]), .add_frac2(af2[1]),
      .add_sign_out(sum_o[1][12]), .add_exp_out(sum_o[1][11:8]), .add_frac_out(sum_o[1][7:0]),
      .busy(bsy[1]), .done_count(dc1), .dbg_state(dbg[1]));

   logic m_r0, m_r1, m_rspv, m_rspid, m_busy;
   logic [12:0] m_res;
   logic [1:0] m_dbg;
   logic [25:0] m_ops;
   logic [31:0] m_done;
   assign m_r0    = r0rdy[sel];
   assign m_r1    = r1rdy[sel];
   assign m_rspv  = rspv[sel];
   assign m_rspid = rspid[sel];
   assign m_busy  = bsy[sel];
   assign m_res   = rres[sel];
   assign m_dbg   = dbg[sel];
   assign m_ops   = {as1[sel], ae1[sel], af1[sel], as2[sel], ae2[sel], af2[sel]};
   assign m_done  = sel ? 32'(dc1) : 32'(dc0);

   // ---------------- scoreboard / monitor ----------------
   logic [13:0] exp_q[$];
   logic [13:0] cur;
   logic [25:0] op_exp = '0;
   logic inflight = 1'b0, rsp_active = 1'b0, m_last = 1'b1, prev_rst = 1'b0;
   logic exp_r0, exp_r1, acc_id;
   int cyc = 0, acc_cyc = 0, done_exp = 0, s_cur = 1, wmask = 255;
   int acc_total[2] = '{0, 0};
   int wait_c[2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (settle=%0d cycle %0d): got %0h, expected %0h", name, s_cur, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s (settle=%0d cycle %0d): %s", name, s_cur, cyc, what);
   endtask

   always @(negedge clk) begin
      s_cur = sel ? S1 : S0;
      wmask = sel ? 15 : 255;
      if (reset) begin
         exp_q.delete();
         inflight = 1'b0;
         rsp_active = 1'b0;
         m_last = 1'b1;
         done_exp = 0;
         op_exp = '0;
         wait_c[0] = 0;
         wait_c[1] = 0;
      end else begin
         if (prev_rst) begin
            check("reset_rsp_valid", 32'(m_rspv), 0);
            check("reset_rsp_id", 32'(m_rspid), 0);
            check("reset_rsp_result", 32'(m_res), 0);
         end
         check("busy", 32'(m_busy), 32'(inflight));
         check("dbg_state_idle", 32'(m_dbg == 2'd0), 32'(!inflight));
         check("done_count", m_done, 32'(done_exp));
         check("add_operands", 32'(m_ops), 32'(op_exp));
         exp_r0 = !inflight && v[0] && (!v[1] || m_last);
         exp_r1 = !inflight && v[1] && (!v[0] || !m_last);
         check("req0_ready", 32'(m_r0), 32'(exp_r0));
         check("req1_ready", 32'(m_r1), 32'(exp_r1));

         if (m_rspv) begin
            if (!rsp_active) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_rsp", "rsp_valid high with no operation outstanding");
               end else begin
                  cur = exp_q.pop_front();
                  check("rsp_latency", 32'(cyc - acc_cyc), 32'(s_cur + 1));
                  check("rsp_id", 32'(m_rspid), 32'(cur[13]));
                  check("rsp_result", 32'(m_res), 32'(cur[12:0]));
                  rsp_active = 1'b1;
               end
            end else begin
               check("rsp_id_hold", 32'(m_rspid), 32'(cur[13]));
               check("rsp_result_hold", 32'(m_res), 32'(cur[12:0]));
            end
            if (rr) begin
               rsp_active = 1'b0;
               inflight = 1'b0;
               done_exp = (done_exp + 1) & wmask;
            end
         end else if (inflight && !rsp_active && (cyc - acc_cyc > s_cur + 1)) begin
            fail_now("rsp_timeout", "no response within settle window");
            inflight = 1'b0;
            exp_q.delete();
         end

         // A held request must be served within one other operation.
         for (int n = 0; n < 2; n++) begin
            if (v[n] && !((n == 0) ? m_r0 : m_r1)) begin
               if (!(m_rspv && !rr)) wait_c[n]++;
               if (wait_c[n] > 2 * (s_cur + 2) + 2) begin
                  fail_now("req_starved", $sformatf("requester %0d waited %0d cycles", n, wait_c[n]));
                  wait_c[n] = 0;
               end
            end else wait_c[n] = 0;
         end

         if ((v[0] && m_r0) || (v[1] && m_r1)) begin
            acc_id = !(v[0] && m_r0);
            exp_q.push_back({acc_id, fp_add(op_a[acc_id], op_b[acc_id] ^ {op_s[acc_id], 12'd0})});
            op_exp = {op_a[acc_id], op_b[acc_id] ^ {op_s[acc_id], 12'd0}};
            m_last = acc_id;
            inflight = 1'b1;
            acc_cyc = cyc;
            acc_total[acc_id]++;
         end
      end
      prev_rst = reset;
   end

   // ---------------- driver tasks (called at posedge + 2) ----------------
   task automatic issue(input int n, input logic [12:0] a, input logic [12:0] b,
                        input logic sub, input int hold);
      int target;
      int t;
      target = acc_total[n] + 1;
      t = 0;
      op_a[n] = a;
      op_b[n] = b;
      op_s[n] = sub;
      v[n] = 1'b1;
      while (acc_total[n] < target) begin
         if (hold > 0 && t >= hold) break;
         @(posedge clk);
         #2;
         t++;
         if (t > 2000) begin
            $display("FAIL issue_timeout: requester %0d never accepted", n);
            $fatal(1);
         end
      end
      v[n] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (inflight || rsp_active || exp_q.size() != 0) begin
         @(posedge clk);
         #2;
         t++;
         if (t > 300) begin
            $display("FAIL wait_idle: operation never completed");
            $fatal(1);
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic rand_reqs(input int n, input int ops);
      for (int i = 0; i < ops; i++) begin
         for (int w = $urandom_range(0, 3); w > 0; w--) begin
            @(posedge clk);
            #2;
         end
         issue(n, 13'($urandom), 13'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? 1 + $urandom_range(0, 2) : 0);
      end
   endtask

   logic rand_on = 1'b0;
   task automatic rand_phase(input int ops);
      rand_on = 1'b1;
      fork
         begin
            fork
               rand_reqs(0, ops);
               rand_reqs(1, ops);
            join
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #2;
               rr = ($urandom_range(0, 3) != 0);
            end
            rr = 1'b1;
         end
      join
      wait_idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      op_a = '0;
      op_b = '0;
      op_s = '0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // settle = 1
      issue(0, 13'h0580, 13'h0580, 1'b0, 0);
      wait_idle();
      issue(1, 13'h0680, 13'h0580, 1'b1, 0);
      wait_idle();
      fork
         begin issue(0, 13'h0312, 13'h0421, 1'b0, 0); issue(0, 13'h1733, 13'h0250, 1'b1, 0); end
         begin issue(1, 13'h0a10, 13'h1905, 1'b0, 0); issue(1, 13'h0444, 13'h0444, 1'b1, 0); end
      join
      wait_idle();
      rr = 1'b0;
      issue(0, 13'h06c0, 13'h0301, 1'b0, 0);
      fork
         issue(1, 13'h0202, 13'h0101, 1'b1, 0);
         begin repeat (6) @(posedge clk); #2; rr = 1'b1; end
      join
      wait_idle();
      rand_phase(30);

      // settle = 3, 4-bit done counter
      sel = 1'b1;
      do_reset();
      issue(0, 13'h0580, 13'h0580, 1'b0, 0);
      wait_idle();
      issue(1, 13'h0680, 13'h0580, 1'b1, 0);
      do_reset();
      fork
         issue(0, 13'h0123, 13'h0456, 1'b0, 0);
         issue(1, 13'h0789, 13'h0abc, 1'b0, 0);
      join
      wait_idle();
      rand_phase(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
